// File: rtl/mem_copy_engine_pkg.sv
// Shared types and defaults for the block-copy engine: FSM encoding,
// copy direction and default RAM geometry.
package mem_copy_engine_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        DIR_ASC  = 1'b0,
        DIR_DESC = 1'b1
    } dir_e;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Read/write pointer and remaining-word counter for the copy engine.
// Pointers wrap modulo 2^ADDR_W and step up or down according to the latched direction.
module mem_copy_addr_gen
    import mem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              desc,
    input  logic              rd_step,
    input  logic              wr_step,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              last_rd
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [ADDR_W-1:0] span_s;
    dir_e              dir_q, dir_d;

    // length-1 modulo the address space; a full-memory copy (length[ADDR_W] set) yields all-ones
    assign span_s = length[ADDR_W-1:0] - PTR_ONE;

    // Next pointer/counter values: load on start, otherwise step on each read/write
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        remain_d = remain_q;
        dir_d    = dir_q;
        if (load) begin
            dir_d    = desc ? DIR_DESC : DIR_ASC;
            rd_ptr_d = desc ? (src_addr + span_s) : src_addr;
            wr_ptr_d = desc ? (dst_addr + span_s) : dst_addr;
            remain_d = length;
        end else begin
            if (rd_step) begin
                rd_ptr_d = (dir_q == DIR_DESC) ? (rd_ptr_q - PTR_ONE) : (rd_ptr_q + PTR_ONE);
                remain_d = remain_q - CNT_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (wr_step) begin
                wr_ptr_d = (dir_q == DIR_DESC) ? (wr_ptr_q - PTR_ONE) : (wr_ptr_q + PTR_ONE);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
        end
    end

    // Pointer and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            remain_q <= CNT_ZERO;
            dir_q    <= DIR_ASC;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            remain_q <= remain_d;
            dir_q    <= dir_d;
        end
    end

    assign rd_ptr  = rd_ptr_q;
    assign wr_ptr  = wr_ptr_q;
    assign last_rd = (remain_q == CNT_ONE);

endmodule

// File: rtl/mem_copy_engine.sv
// Block-copy engine in front of the two-port data RAM: passes the processor
// ports through while idle and streams one word per cycle from port 1 to port 2 while copying.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] cpu_address1,
    input  logic [ADDR_W-1:0] cpu_address2,
    input  logic [DATA_W-1:0] cpu_datain1,
    input  logic [DATA_W-1:0] cpu_datain2,
    input  logic              cpu_mem_write1,
    input  logic              cpu_mem_write2,
    input  logic [DATA_W-1:0] ram_dataout1,
    output logic [ADDR_W-1:0] ram_address1,
    output logic [ADDR_W-1:0] ram_address2,
    output logic [DATA_W-1:0] ram_datain1,
    output logic [DATA_W-1:0] ram_datain2,
    output logic              ram_mem_write1,
    output logic              ram_mem_write2
);

    localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_e            state_q, state_d;
    logic              wr_pending_q, wr_pending_d;
    logic              desc_s, load_s, rd_step_s, last_rd_s;
    logic [ADDR_W:0]   src_ext_s, dst_ext_s;
    logic [ADDR_W-1:0] rd_ptr_s, wr_ptr_s;

    // Overlap test is done one bit wider so src+length never wraps; wrap-only overlap stays ascending
    assign src_ext_s = {1'b0, src_addr};
    assign dst_ext_s = {1'b0, dst_addr};
    assign desc_s    = (dst_ext_s > src_ext_s) && (dst_ext_s < (src_ext_s + length));
    assign load_s    = (state_q == ST_IDLE) && start && (length != LEN_ZERO);
    assign rd_step_s = (state_q == ST_RUN);

    mem_copy_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .desc     (desc_s),
        .rd_step  (rd_step_s),
        .wr_step  (wr_pending_q),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .rd_ptr   (rd_ptr_s),
        .wr_ptr   (wr_ptr_s),
        .last_rd  (last_rd_s)
    );

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        wr_pending_d = rd_step_s;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length != LEN_ZERO) ? ST_RUN : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_rd_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and write-pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_pending_q <= wr_pending_d;
        end
    end

    // RAM port mux; write data comes straight from the RAM's registered read port
    always_comb begin
        ram_address1   = cpu_address1;
        ram_address2   = cpu_address2;
        ram_datain1    = cpu_datain1;
        ram_datain2    = cpu_datain2;
        ram_mem_write1 = cpu_mem_write1;
        ram_mem_write2 = cpu_mem_write2;
        if (state_q != ST_IDLE) begin
            ram_address1   = rd_ptr_s;
            ram_datain1    = DATA_ZERO;
            ram_mem_write1 = 1'b0;
            ram_address2   = wr_ptr_s;
            ram_datain2    = ram_dataout1;
            ram_mem_write2 = (state_q == ST_DONE) ? 1'b0 : wr_pending_q;
        end else begin
            ram_mem_write2 = cpu_mem_write2;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: owns a 4096x12 two-port RAM, predicts every copy with a
// word-level reference model and checks the port schedule and memory image.
module tb_mem_copy_engine;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] src_addr, dst_addr;
    logic [12:0] length;
    logic        busy, done;
    logic [11:0] cpu_address1, cpu_address2, cpu_datain1, cpu_datain2;
    logic        cpu_mem_write1, cpu_mem_write2;
    logic [11:0] ram_dataout1;
    logic [11:0] ram_address1, ram_address2, ram_datain1, ram_datain2;
    logic        ram_mem_write1, ram_mem_write2;

    logic [11:0] mem     [DEPTH];
    logic [11:0] ref_mem [DEPTH];
    logic [11:0] exp_data[DEPTH];

    int checks = 0;
    int errors = 0;

    bit trk = 1'b0;
    int trk_cyc, trk_src, trk_dst, trk_len;
    bit trk_desc;

    mem_copy_engine dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done),
        .cpu_address1(cpu_address1), .cpu_address2(cpu_address2),
        .cpu_datain1(cpu_datain1), .cpu_datain2(cpu_datain2),
        .cpu_mem_write1(cpu_mem_write1), .cpu_mem_write2(cpu_mem_write2),
        .ram_dataout1(ram_dataout1),
        .ram_address1(ram_address1), .ram_address2(ram_address2),
        .ram_datain1(ram_datain1), .ram_datain2(ram_datain2),
        .ram_mem_write1(ram_mem_write1), .ram_mem_write2(ram_mem_write2)
    );

    always #5 clk = ~clk;

    // Two-port RAM with registered port-1 read (read returns pre-write data)
    always @(posedge clk) begin
        ram_dataout1 <= mem[ram_address1];
        if (ram_mem_write1) mem[ram_address1] <= ram_datain1;
        if (ram_mem_write2) mem[ram_address2] <= ram_datain2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] rd_addr(input int k);
        int v;
        v = trk_desc ? (trk_src + trk_len - 1 - k) : (trk_src + k);
        return v[11:0];
    endfunction

    function automatic logic [11:0] wr_addr(input int k);
        int v;
        v = trk_desc ? (trk_dst + trk_len - 1 - k) : (trk_dst + k);
        return v[11:0];
    endfunction

    // Word-level model: read k is seen before write k-1 lands (one-word read-ahead)
    task automatic model_copy(input int s, input int d, input int l);
        logic [11:0] pa, pd, a, v;
        bit pend;
        trk_src  = s;
        trk_dst  = d;
        trk_len  = l;
        trk_desc = (d > s) && (d < s + l);
        pend = 1'b0;
        pa = 12'h000;
        pd = 12'h000;
        for (int k = 0; k < l; k++) begin
            a = rd_addr(k);
            v = ref_mem[a];
            if (pend) ref_mem[pa] = pd;
            exp_data[k] = v;
            pa = wr_addr(k);
            pd = v;
            pend = 1'b1;
        end
        if (pend) ref_mem[pa] = pd;
    endtask

    // Per-cycle comparison of busy/done and both RAM ports against the expected schedule
    task automatic compare_loop();
        int c, n;
        bit exp_busy, exp_we;
        forever begin
            @(negedge clk);
            if (trk) begin
                c = trk_cyc;
                n = (trk_len == 0) ? 1 : trk_len + 2;
                exp_busy = (c >= 1) && (c <= n);
                check("busy", {31'd0, busy}, {31'd0, exp_busy});
                check("done", {31'd0, done}, {31'd0, (c == n)});
                if (!exp_busy) begin
                    check("pass_addr1", {20'd0, ram_address1}, {20'd0, cpu_address1});
                    check("pass_addr2", {20'd0, ram_address2}, {20'd0, cpu_address2});
                    check("pass_we2", {31'd0, ram_mem_write2}, {31'd0, cpu_mem_write2});
                end else begin
                    check("we1", {31'd0, ram_mem_write1}, 32'd0);
                    check("din1", {20'd0, ram_datain1}, 32'd0);
                    if (c <= trk_len) check("rd_addr", {20'd0, ram_address1}, {20'd0, rd_addr(c - 1)});
                    exp_we = (trk_len > 0) && (c >= 2) && (c <= trk_len + 1);
                    check("we2", {31'd0, ram_mem_write2}, {31'd0, exp_we});
                    if (exp_we) begin
                        check("wr_addr", {20'd0, ram_address2}, {20'd0, wr_addr(c - 2)});
                        check("wr_data", {20'd0, ram_datain2}, {20'd0, exp_data[c - 2]});
                    end
                end
                if (c >= n + 1) trk = 1'b0;
                else trk_cyc = c + 1;
            end
        end
    endtask

    task automatic check_image(input string name);
        int nmis;
        nmis = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nmis++;
        check(name, nmis, 32'd0);
    endtask

    task automatic cpu_write(input int a, input logic [11:0] v);
        @(posedge clk); #1;
        cpu_address1 = a[11:0]; cpu_datain1 = v; cpu_mem_write1 = 1'b1;
        ref_mem[a[11:0]] = v;
        @(posedge clk); #1;
        cpu_mem_write1 = 1'b0;
    endtask

    task automatic run_copy(input int s, input int d, input int l, input bit ign);
        @(posedge clk); #1;
        model_copy(s, d, l);
        cpu_address1 = 12'($urandom); cpu_address2 = 12'($urandom);
        cpu_datain1 = 12'($urandom); cpu_datain2 = 12'($urandom);
        src_addr = s[11:0]; dst_addr = d[11:0]; length = l[12:0]; start = 1'b1;
        trk_cyc = 0; trk = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_addr = 12'($urandom); dst_addr = 12'($urandom); length = 13'($urandom_range(1, 50));
        if (ign) begin
            @(posedge clk); #1;
            start = 1'b1; src_addr = 12'h100; dst_addr = 12'h900; length = 13'd4;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 6000 && trk; i++) begin
            @(negedge clk); #1;
        end
        if (trk) begin
            check("copy_timeout", 32'd1, 32'd0);
            trk = 1'b0;
        end
        check_image("mem_image");
    endtask

    initial begin
        logic [11:0] v0, v1, v2;
        int s, d, l;
        reset = 1'b1; start = 1'b0;
        src_addr = 12'h000; dst_addr = 12'h000; length = 13'd0;
        cpu_address1 = 12'h123; cpu_address2 = 12'h456;
        cpu_datain1 = 12'h000; cpu_datain2 = 12'h000;
        cpu_mem_write1 = 1'b0; cpu_mem_write2 = 1'b0;
        fork compare_loop(); join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_pass_addr1", {20'd0, ram_address1}, 32'h123);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fill whole RAM with random data through the pass-through ports
        for (int a = 0; a < DEPTH; a += 2) begin
            @(posedge clk); #1;
            cpu_address1 = a[11:0];       cpu_datain1 = 12'($urandom); cpu_mem_write1 = 1'b1;
            cpu_address2 = a[11:0] + 12'd1; cpu_datain2 = 12'($urandom); cpu_mem_write2 = 1'b1;
            ref_mem[a] = cpu_datain1;
            ref_mem[a + 1] = cpu_datain2;
        end
        @(posedge clk); #1;
        cpu_mem_write1 = 1'b0; cpu_mem_write2 = 1'b0;
        check_image("fill_image");

        // Pass-through write then read-back
        cpu_address1 = 12'h010; cpu_datain1 = 12'hABC; cpu_mem_write1 = 1'b1;
        ref_mem[12'h010] = 12'hABC;
        @(negedge clk);
        check("pt_addr1", {20'd0, ram_address1}, 32'h010);
        check("pt_we1", {31'd0, ram_mem_write1}, 32'd1);
        check("pt_din1", {20'd0, ram_datain1}, 32'hABC);
        @(posedge clk); #1;
        cpu_mem_write1 = 1'b0;
        @(posedge clk); #1;
        check("pt_readback", {20'd0, ram_dataout1}, 32'hABC);

        // Basic copy
        for (int i = 0; i < 4; i++) cpu_write(12'h100 + i, 12'(i + 1));
        run_copy(12'h100, 12'h200, 4, 1'b0);
        for (int i = 0; i < 4; i++) check("basic_word", {20'd0, mem[12'h200 + i]}, i + 1);

        // Overlap, dst above src: descending
        for (int i = 0; i < 5; i++) cpu_write(12'h40 + i, 12'(10 + i));
        run_copy(12'h40, 12'h42, 5, 1'b0);
        for (int i = 0; i < 5; i++) check("ovl_desc_word", {20'd0, mem[12'h42 + i]}, 10 + i);
        // Overlap, dst below src: ascending
        for (int i = 0; i < 5; i++) cpu_write(12'h42 + i, 12'(10 + i));
        run_copy(12'h42, 12'h40, 5, 1'b0);
        for (int i = 0; i < 5; i++) check("ovl_asc_word", {20'd0, mem[12'h40 + i]}, 10 + i);

        // Source block wrapping past the top of memory
        cpu_write(12'hFFE, 12'h111); cpu_write(12'hFFF, 12'h222);
        cpu_write(12'h000, 12'h333); cpu_write(12'h001, 12'h444);
        run_copy(12'hFFE, 12'h010, 4, 1'b0);
        check("wrap_w0", {20'd0, mem[12'h010]}, 32'h111);
        check("wrap_w1", {20'd0, mem[12'h011]}, 32'h222);
        check("wrap_w2", {20'd0, mem[12'h012]}, 32'h333);
        check("wrap_w3", {20'd0, mem[12'h013]}, 32'h444);

        // Zero-length copy and a start pulse during a running copy
        run_copy(12'h300, 12'h305, 0, 1'b0);
        run_copy(12'h500, 12'h600, 8, 1'b1);

        // Reset mid-copy: only the first two writes may land
        v0 = ref_mem[12'h700]; v1 = ref_mem[12'h701]; v2 = ref_mem[12'h802];
        @(posedge clk); #1;
        src_addr = 12'h700; dst_addr = 12'h800; length = 13'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we2", {31'd0, ram_mem_write2}, 32'd0);
        check("rst_pass_addr2", {20'd0, ram_address2}, {20'd0, cpu_address2});
        @(posedge clk); #1;
        reset = 1'b0;
        ref_mem[12'h800] = v0;
        ref_mem[12'h801] = v1;
        check("rst_w0", {20'd0, mem[12'h800]}, {20'd0, v0});
        check("rst_w1", {20'd0, mem[12'h801]}, {20'd0, v1});
        check("rst_w2_untouched", {20'd0, mem[12'h802]}, {20'd0, v2});
        check_image("rst_image");
        run_copy(12'h700, 12'h800, 8, 1'b0);

        // Randomized copies, plus one full-memory copy
        for (int t = 0; t < 14; t++) begin
            s = $urandom_range(0, 4095);
            l = $urandom_range(1, 40);
            case ($urandom_range(0, 2))
                0: d = $urandom_range(0, 4095);
                1: d = (s + $urandom_range(1, l)) % DEPTH;
                default: d = (s + DEPTH - $urandom_range(1, l)) % DEPTH;
            endcase
            run_copy(s, d, l, t[0]);
        end
        run_copy(12'h123, 12'h456, 4096, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
